sdram_write_burst: RTL and testbench
====================================

Name: sdram_write_burst

Overview:
Parametrised SDRAM write controller. It is the successor of the fixed 16-bit single-row writer. It sits between the arbiter and the SDRAM command/DQ mux and drives ACTIVE / WRITE / BURST-STOP / PRECHARGE sequences. It adds configurable widths and timings, and automatic row/bank crossing when a burst runs past the end of a page. The SDRAM mode register is set to full-page burst by sdram_init.

Parameters:
DATA_W, 16, SDRAM DQ width
BANK_W, 2, bank address width
ROW_W, 13, row address width (also wr_sdram_addr width; must be >= COL_W+2)
COL_W, 9, column address width; page = 2^COL_W words
LEN_W, 10, burst length field width
T_RCD, 2, NOP cycles between ACTIVE and WRITE (>=1)
T_WR, 2, NOP cycles between BURST-STOP and PRECHARGE (>=1)
T_RP, 2, NOP cycles after PRECHARGE (>=1)

Ports:
wr_clk  in  1  clock
wr_rst  in  1  asynchronous reset, active-high
init_end  in  1  SDRAM initialisation complete
wr_en  in  1  write request (level)
wr_addr  in  BANK_W+ROW_W+COL_W  start address {bank,row,col}
wr_data  in  DATA_W  write data, consumed on wr_ack
wr_bst_len  in  LEN_W  number of words
wr_ack  out  1  current wr_data is being written this cycle
wr_end  out  1  one-cycle pulse, burst complete
wr_busy  out  1  high whenever state != IDLE
wr_sdram_en  out  1  DQ output enable
wr_sdram_cmd  out  4  {cs_n,ras_n,cas_n,we_n}
wr_sdram_bank  out  BANK_W  bank
wr_sdram_addr  out  ROW_W  A bus
wr_sdram_data  out  DATA_W  DQ drive value

Behaviour:
- Commands: NOP 0111, ACT 0011, WRITE 0100, BST 0110, PRE 0010.
- Reset values (asynchronous, also mid-burst): cmd NOP, bank 0, addr 0, data 0, en/ack/end/busy 0, state IDLE, counters 0. No recovery sequence; the next burst starts with ACT.
- States: IDLE, ACT, TRCD, WR, DATA, BST, TWR, PRE, TRP, END.
- IDLE -> ACT when init_end & wr_en & wr_bst_len != 0.
  - wr_addr and wr_bst_len are latched on that edge.
  - Length 0 or init_end low: the controller stays IDLE and wr_end is not pulsed.
  - wr_en changes after start are ignored until END.
- ACT (1 cycle): cmd ACT, bank/addr = current bank/row. -> TRCD.
- TRCD: exactly T_RCD NOP cycles. -> WR.
- WR (1 cycle): cmd WRITE, addr = {A10=0, current col zero-extended}. This cycle carries beat 0.
- DATA: remaining beats of this segment, with cmd NOP.
- Segment length = min(remaining, 2^COL_W - col).
- wr_ack = wr_sdram_en = 1 in every beat cycle (WR and DATA) and 0 otherwise.
- wr_sdram_data = wr_data combinationally during beats and 0 otherwise. The user advances wr_data on the edge after each wr_ack.
- After the last beat of a segment -> BST (1 cycle, en=0).
- BST -> TWR, which is T_WR NOP cycles.
- TWR -> PRE (1 cycle): cmd PRE, A10=1 (all banks).
- PRE -> TRP, which is T_RP NOP cycles.
- After TRP: if remaining != 0 -> ACT; otherwise -> END.
- Address update on a segment boundary: col = 0, row = row+1. If row wraps from all-ones to 0, bank = bank+1, and bank wraps modulo 2^BANK_W.
- END: 1 cycle with wr_end = 1, then IDLE. wr_busy drops in the IDLE cycle.
- Timing: with wr_bst_len = L and no crossing, ACT is issued on the first clock after the start edge. Beats occupy cycles T_RCD+1 .. T_RCD+L counted from ACT = cycle 0. wr_end occurs at cycle T_RCD+L+T_WR+T_RP+3.
- Remaining counter: LEN_W+1 bits, so no overflow on the maximum length.

Test Plan:
- Default params, addr 0, len 10, data 0..9:
  - ACT at c0, WRITE col 0 at c3, ack high c3..c12 with DQ 0..9.
  - BST c13, PRE (A10=1) c16, wr_end c19.
  - W989DxDB readback of cols 0..9 = 0..9.
- Page cross: bank 1, row 5, col 508, len 10:
  - 4 beats at row 5 cols 508..511, then BST/PRE.
  - ACT row 6, WRITE col 0, 6 beats, single wr_end.
  - Total ack count = 10.
- Row wrap: bank 0, row 8191, col 510, len 4 -> 2 beats in bank 0 row 8191, then ACT bank 1 row 0 col 0 with 2 beats.
- Gating:
  - wr_en = 1 with len 0 -> no command other than NOP, busy stays 0.
  - wr_en = 1 with init_end = 0 -> same.
  - Raising init_end with len 3 -> burst starts on the next edge.
- Reset mid-burst: assert wr_rst during beat 4 of a len-10 burst.
  - Outputs go to reset values immediately, ack 0, no wr_end.
  - After release, a new len-2 burst completes normally.
- Params DATA_W=32, COL_W=8, T_RCD=3, T_WR=1, T_RP=3, len 256 at col 0:
  - One segment, 256 beats starting at c4.
  - wr_end at c266, with no second ACT.

Source files
------------

// File: rtl/sdram_write_burst.sv
// sdram_write_burst: parametrised SDRAM write-burst controller.
// Issues ACTIVE / WRITE / BURST-STOP / PRECHARGE sequences for a full-page
// burst. A burst that runs past the end of a page is split into segments;
// each new segment opens the next row, and the next bank when the row wraps.
module sdram_write_burst #(
  parameter int DATA_W = 16,
  parameter int BANK_W = 2,
  parameter int ROW_W  = 13,
  parameter int COL_W  = 9,
  parameter int LEN_W  = 10,
  parameter int T_RCD  = 2,
  parameter int T_WR   = 2,
  parameter int T_RP   = 2
) (
  input  logic                            wr_clk,
  input  logic                            wr_rst,
  input  logic                            init_end,
  input  logic                            wr_en,
  input  logic [BANK_W+ROW_W+COL_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]               wr_data,
  input  logic [LEN_W-1:0]                wr_bst_len,
  output logic                            wr_ack,
  output logic                            wr_end,
  output logic                            wr_busy,
  output logic                            wr_sdram_en,
  output logic [3:0]                      wr_sdram_cmd,
  output logic [BANK_W-1:0]               wr_sdram_bank,
  output logic [ROW_W-1:0]                wr_sdram_addr,
  output logic [DATA_W-1:0]               wr_sdram_data
);

  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_BST   = 4'b0110;
  localparam logic [3:0] CMD_PRE   = 4'b0010;

  // A10 high during PRECHARGE selects all banks.
  localparam logic [ROW_W-1:0] ADDR_A10 = ROW_W'(1) << 10;

  localparam logic [7:0] RCD_LAST = 8'(T_RCD - 1);
  localparam logic [7:0] WR_LAST  = 8'(T_WR - 1);
  localparam logic [7:0] RP_LAST  = 8'(T_RP - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_ACT, S_TRCD, S_WR, S_DATA, S_BST, S_TWR, S_PRE, S_TRP, S_END
  } state_t;

  state_t             state, state_nxt;
  logic [7:0]         wait_cnt;
  logic [LEN_W:0]     remaining;   // one extra bit: the maximum length never overflows
  logic [BANK_W-1:0]  bank_r;
  logic [ROW_W-1:0]   row_r;
  logic [COL_W-1:0]   col_r;

  logic start, beat, last_beat, in_wait;

  assign start     = init_end & wr_en & (wr_bst_len != '0);
  assign beat      = (state == S_WR) || (state == S_DATA);
  // A segment ends on the last word of the burst or the last column of the page.
  assign last_beat = (remaining == (LEN_W+1)'(1)) || (col_r == '1);
  assign in_wait   = (state == S_TRCD) || (state == S_TWR) || (state == S_TRP);

  // State register.
  // NOTE: asynchronous reset lives in the sensitivity list; every flop in this
  // design returns to its idle value the instant wr_rst rises, even mid-burst.
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  // NOTE: assigning a default before the case keeps every path covered, so no
  // latch is inferred for state_nxt.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = S_ACT;
      S_ACT:  state_nxt = S_TRCD;
      S_TRCD: if (wait_cnt == RCD_LAST) state_nxt = S_WR;
      S_WR,
      S_DATA: state_nxt = last_beat ? S_BST : S_DATA;
      S_BST:  state_nxt = S_TWR;
      S_TWR:  if (wait_cnt == WR_LAST) state_nxt = S_PRE;
      S_PRE:  state_nxt = S_TRP;
      S_TRP:  if (wait_cnt == RP_LAST) state_nxt = (remaining != '0) ? S_ACT : S_END;
      S_END:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Wait counter for the NOP gaps (TRCD / TWR / TRP); clears on leaving a gap.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours.
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst)                              wait_cnt <= '0;
    else if (in_wait && state_nxt == state)  wait_cnt <= wait_cnt + 8'd1;
    else                                     wait_cnt <= '0;
  end

  // Burst address and length tracking: latch on start, advance per beat,
  // step to the next row (and bank on row wrap) between segments.
  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      remaining <= '0;
      bank_r    <= '0;
      row_r     <= '0;
      col_r     <= '0;
    end else if (state == S_IDLE && start) begin
      remaining <= {1'b0, wr_bst_len};
      bank_r    <= wr_addr[BANK_W+ROW_W+COL_W-1:ROW_W+COL_W];
      row_r     <= wr_addr[ROW_W+COL_W-1:COL_W];
      col_r     <= wr_addr[COL_W-1:0];
    end else if (beat) begin
      // The column wraps to 0 naturally after the last word of a page.
      remaining <= remaining - (LEN_W+1)'(1);
      col_r     <= col_r + COL_W'(1);
    end else if (state == S_TRP && state_nxt == S_ACT) begin
      row_r <= row_r + ROW_W'(1);
      if (row_r == '1) bank_r <= bank_r + BANK_W'(1);
    end
  end

  // Output decode from the current state.
  always_comb begin
    wr_sdram_cmd  = CMD_NOP;
    wr_sdram_bank = '0;
    wr_sdram_addr = '0;
    wr_ack        = 1'b0;
    wr_end        = 1'b0;
    case (state)
      S_ACT: begin
        wr_sdram_cmd  = CMD_ACT;
        wr_sdram_bank = bank_r;
        wr_sdram_addr = row_r;
      end
      S_WR: begin
        // Column zero-extended onto the A bus; A10 stays 0 (no auto-precharge).
        wr_sdram_cmd  = CMD_WRITE;
        wr_sdram_bank = bank_r;
        wr_sdram_addr = ROW_W'(col_r);
        wr_ack        = 1'b1;
      end
      S_DATA: wr_ack = 1'b1;
      S_BST:  wr_sdram_cmd = CMD_BST;
      S_PRE: begin
        wr_sdram_cmd  = CMD_PRE;
        wr_sdram_bank = bank_r;
        wr_sdram_addr = ADDR_A10;
      end
      S_END:  wr_end = 1'b1;
      default: ;
    endcase
  end

  assign wr_busy       = (state != S_IDLE);
  assign wr_sdram_en   = wr_ack;
  assign wr_sdram_data = wr_ack ? wr_data : '0;

endmodule

// File: tb/tb_sdram_write_burst.sv
// Directed bench for sdram_write_burst: a default-parameter instance (a) and
// a 32-bit / 256-word-page instance (b) share clock, reset and init_end.
module tb_sdram_write_burst;

  localparam logic [3:0] NOP = 4'b0111, ACT = 4'b0011, WRT = 4'b0100,
                         BST = 4'b0110, PRE = 4'b0010;

  logic clk = 1'b0;
  logic rst, init_end;
  always #5 clk = ~clk;

  // instance a
  logic        wr_en;
  logic [23:0] wr_addr;
  logic [15:0] wr_data;
  logic [9:0]  wr_bst_len;
  logic        ack_a, end_a, busy_a, en_a;
  logic [3:0]  cmd_a;
  logic [1:0]  bank_a;
  logic [12:0] addr_a;
  logic [15:0] dq_a;

  // instance b
  logic        wr_en_b;
  logic [22:0] wr_addr_b;
  logic [31:0] wr_data_b;
  logic [9:0]  wr_bst_len_b;
  logic        ack_b, end_b, busy_b, en_b;
  logic [3:0]  cmd_b;
  logic [1:0]  bank_b;
  logic [12:0] addr_b;
  logic [31:0] dq_b;

  sdram_write_burst dut_a (
    .wr_clk(clk), .wr_rst(rst), .init_end(init_end), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_bst_len(wr_bst_len),
    .wr_ack(ack_a), .wr_end(end_a), .wr_busy(busy_a), .wr_sdram_en(en_a),
    .wr_sdram_cmd(cmd_a), .wr_sdram_bank(bank_a), .wr_sdram_addr(addr_a),
    .wr_sdram_data(dq_a)
  );

  sdram_write_burst #(
    .DATA_W(32), .COL_W(8), .T_RCD(3), .T_WR(1), .T_RP(3)
  ) dut_b (
    .wr_clk(clk), .wr_rst(rst), .init_end(init_end), .wr_en(wr_en_b),
    .wr_addr(wr_addr_b), .wr_data(wr_data_b), .wr_bst_len(wr_bst_len_b),
    .wr_ack(ack_b), .wr_end(end_b), .wr_busy(busy_b), .wr_sdram_en(en_b),
    .wr_sdram_cmd(cmd_b), .wr_sdram_bank(bank_b), .wr_sdram_addr(addr_b),
    .wr_sdram_data(dq_b)
  );

  int vectors = 0;
  int miscompares = 0;

  // Per-cycle trace of one burst, cycle 0 = first cycle after the start edge.
  logic [3:0]  cmd_t  [0:511];
  logic [31:0] addr_t [0:511];
  logic [31:0] bank_t [0:511];
  logic        ack_t  [0:511];
  logic        busy_t [0:511];
  int n_cyc, end_cyc, end_cnt, ack_cnt, act_cnt, first_ack;
  logic [31:0] mem [int];   // reconstructed SDRAM contents keyed by bank/row/col

  function automatic int key(input int b, input int r, input int c);
    return (b << 24) | (r << 10) | c;
  endfunction

  task automatic start(input bit sel, input int bk, input int row, input int col,
                       input int len, input logic [31:0] base);
    @(negedge clk);
    if (!sel) begin
      wr_addr = {bk[1:0], row[12:0], col[8:0]};
      wr_bst_len = len[9:0];
      wr_data = base[15:0];
      wr_en = 1'b1;
    end else begin
      wr_addr_b = {bk[1:0], row[12:0], col[7:0]};
      wr_bst_len_b = len[9:0];
      wr_data_b = base;
      wr_en_b = 1'b1;
    end
  endtask

  // Records the bus each cycle and plays the SDRAM: ACT opens a row, WRITE
  // sets the column, each acked beat stores DQ and advances the column.
  task automatic capture(input bit sel, input int max_cyc, input logic [31:0] base);
    int beat, cb, cr, cc;
    logic [3:0] c;
    logic [31:0] a, bk, dq;
    logic ak, e, bz;
    beat = 0; cb = 0; cr = 0; cc = 0;
    n_cyc = 0; end_cyc = -1; end_cnt = 0; ack_cnt = 0; act_cnt = 0; first_ack = -1;
    mem.delete();
    for (int k = 0; k < max_cyc; k++) begin
      @(negedge clk);
      wr_en = 1'b0;
      wr_en_b = 1'b0;
      if (!sel) begin
        c = cmd_a; a = 32'(addr_a); bk = 32'(bank_a); dq = 32'(dq_a);
        ak = ack_a; e = end_a; bz = busy_a;
      end else begin
        c = cmd_b; a = 32'(addr_b); bk = 32'(bank_b); dq = dq_b;
        ak = ack_b; e = end_b; bz = busy_b;
      end
      cmd_t[k] = c; addr_t[k] = a; bank_t[k] = bk; ack_t[k] = ak; busy_t[k] = bz;
      n_cyc = k + 1;
      if (c == ACT) begin act_cnt++; cb = int'(bk); cr = int'(a); end
      if (c == WRT) cc = int'(a);
      if (ak) begin
        mem[key(cb, cr, cc)] = dq;
        cc++;
        ack_cnt++;
        if (first_ack < 0) first_ack = k;
        beat++;
        wr_data = 16'(base + 32'(beat));
        wr_data_b = base + 32'(beat);
      end
      if (e) begin
        end_cnt++;
        if (end_cyc < 0) end_cyc = k;
      end
      if (end_cyc >= 0 && k == end_cyc + 1) break;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; init_end = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_bst_len = '0;
    wr_en_b = 1'b0; wr_addr_b = '0; wr_data_b = '0; wr_bst_len_b = '0;
    #2;
    vectors++; if (cmd_a !== NOP) begin miscompares++; $display("FAIL reset_cmd got %b want %b", cmd_a, NOP); end
    vectors++; if ({ack_a, end_a, busy_a, en_a} !== 4'b0) begin miscompares++; $display("FAIL reset_flags got %b want 0000", {ack_a, end_a, busy_a, en_a}); end
    vectors++; if ({bank_a, addr_a, dq_a} !== '0) begin miscompares++; $display("FAIL reset_bus got %h want 0", {bank_a, addr_a, dq_a}); end
    vectors++; if ({cmd_b, ack_b, end_b, busy_b, en_b} !== {NOP, 4'b0}) begin miscompares++; $display("FAIL reset_b got %b want %b", {cmd_b, ack_b, end_b, busy_b, en_b}, {NOP, 4'b0}); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    init_end = 1'b1;
  endtask

  task automatic test_basic;
    start(0, 0, 0, 0, 10, 32'd0);
    capture(0, 100, 32'd0);
    vectors++; if (end_cyc !== 19) begin miscompares++; $display("FAIL basic_end_cycle got %0d want 19", end_cyc); end
    vectors++; if ({cmd_t[0], bank_t[0], addr_t[0]} !== {ACT, 32'd0, 32'd0}) begin miscompares++; $display("FAIL basic_act got %b/%0d/%0d want ACT/0/0", cmd_t[0], bank_t[0], addr_t[0]); end
    vectors++; if ({cmd_t[1], cmd_t[2]} !== {NOP, NOP}) begin miscompares++; $display("FAIL basic_trcd got %b %b want NOP NOP", cmd_t[1], cmd_t[2]); end
    vectors++; if ({cmd_t[3], addr_t[3]} !== {WRT, 32'd0}) begin miscompares++; $display("FAIL basic_write got %b/%0d want WRITE/0", cmd_t[3], addr_t[3]); end
    for (int k = 2; k <= 13; k++) begin
      vectors++;
      if (ack_t[k] !== (k >= 3 && k <= 12)) begin miscompares++; $display("FAIL basic_ack c%0d got %b", k, ack_t[k]); end
    end
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (mem[key(0, 0, i)] !== 32'(i)) begin miscompares++; $display("FAIL basic_data col%0d got %h want %h", i, mem[key(0, 0, i)], i); end
    end
    vectors++; if (cmd_t[13] !== BST) begin miscompares++; $display("FAIL basic_bst got %b want %b", cmd_t[13], BST); end
    vectors++; if ({cmd_t[14], cmd_t[15]} !== {NOP, NOP}) begin miscompares++; $display("FAIL basic_twr got %b %b want NOP NOP", cmd_t[14], cmd_t[15]); end
    vectors++; if ({cmd_t[16], addr_t[16][10]} !== {PRE, 1'b1}) begin miscompares++; $display("FAIL basic_pre got %b/A10=%b want PRE/1", cmd_t[16], addr_t[16][10]); end
    vectors++; if (busy_t[18] !== 1'b1 || busy_t[20] !== 1'b0) begin miscompares++; $display("FAIL basic_busy got %b,%b want 1,0", busy_t[18], busy_t[20]); end
  endtask

  task automatic test_page_cross;
    start(0, 1, 5, 508, 10, 32'h100);
    capture(0, 100, 32'h100);
    vectors++; if (ack_cnt !== 10) begin miscompares++; $display("FAIL cross_acks got %0d want 10", ack_cnt); end
    vectors++; if (act_cnt !== 2) begin miscompares++; $display("FAIL cross_acts got %0d want 2", act_cnt); end
    vectors++; if (end_cnt !== 1 || end_cyc !== 28) begin miscompares++; $display("FAIL cross_end got %0d@%0d want 1@28", end_cnt, end_cyc); end
    vectors++; if ({cmd_t[7], cmd_t[10]} !== {BST, PRE}) begin miscompares++; $display("FAIL cross_seg1_close got %b %b want BST PRE", cmd_t[7], cmd_t[10]); end
    vectors++; if ({cmd_t[13], bank_t[13], addr_t[13]} !== {ACT, 32'd1, 32'd6}) begin miscompares++; $display("FAIL cross_act2 got %b/%0d/%0d want ACT/1/6", cmd_t[13], bank_t[13], addr_t[13]); end
    vectors++; if ({cmd_t[16], addr_t[16]} !== {WRT, 32'd0}) begin miscompares++; $display("FAIL cross_write2 got %b/%0d want WRITE/0", cmd_t[16], addr_t[16]); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (mem[key(1, 5, 508 + i)] !== 32'h100 + 32'(i)) begin miscompares++; $display("FAIL cross_data_r5 col%0d got %h want %h", 508 + i, mem[key(1, 5, 508 + i)], 32'h100 + 32'(i)); end
    end
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (mem[key(1, 6, i)] !== 32'h104 + 32'(i)) begin miscompares++; $display("FAIL cross_data_r6 col%0d got %h want %h", i, mem[key(1, 6, i)], 32'h104 + 32'(i)); end
    end
  endtask

  task automatic test_row_wrap;
    start(0, 0, 8191, 510, 4, 32'h200);
    capture(0, 100, 32'h200);
    vectors++; if (ack_cnt !== 4 || act_cnt !== 2) begin miscompares++; $display("FAIL wrap_counts got ack=%0d act=%0d want 4,2", ack_cnt, act_cnt); end
    vectors++; if ({bank_t[0], addr_t[0]} !== {32'd0, 32'd8191}) begin miscompares++; $display("FAIL wrap_act1 got %0d/%0d want 0/8191", bank_t[0], addr_t[0]); end
    vectors++; if ({cmd_t[11], bank_t[11], addr_t[11]} !== {ACT, 32'd1, 32'd0}) begin miscompares++; $display("FAIL wrap_act2 got %b/%0d/%0d want ACT/1/0", cmd_t[11], bank_t[11], addr_t[11]); end
    vectors++; if ({mem[key(0, 8191, 510)], mem[key(0, 8191, 511)]} !== {32'h200, 32'h201}) begin miscompares++; $display("FAIL wrap_data_b0 got %h %h want 200 201", mem[key(0, 8191, 510)], mem[key(0, 8191, 511)]); end
    vectors++; if ({mem[key(1, 0, 0)], mem[key(1, 0, 1)]} !== {32'h202, 32'h203}) begin miscompares++; $display("FAIL wrap_data_b1 got %h %h want 202 203", mem[key(1, 0, 0)], mem[key(1, 0, 1)]); end
  endtask

  task automatic test_gating;
    @(negedge clk);
    wr_addr = '0; wr_bst_len = 10'd0; wr_en = 1'b1; init_end = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      vectors++; if ({cmd_a, busy_a, end_a} !== {NOP, 2'b00}) begin miscompares++; $display("FAIL gate_len0 c%0d got %b want %b", k, {cmd_a, busy_a, end_a}, {NOP, 2'b00}); end
    end
    wr_bst_len = 10'd3; init_end = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      vectors++; if ({cmd_a, busy_a, end_a} !== {NOP, 2'b00}) begin miscompares++; $display("FAIL gate_noinit c%0d got %b want %b", k, {cmd_a, busy_a, end_a}, {NOP, 2'b00}); end
    end
    init_end = 1'b1;
    capture(0, 100, 32'd0);
    vectors++; if (cmd_t[0] !== ACT) begin miscompares++; $display("FAIL gate_start got %b want %b", cmd_t[0], ACT); end
    vectors++; if (end_cyc !== 12 || ack_cnt !== 3) begin miscompares++; $display("FAIL gate_burst got end=%0d ack=%0d want 12,3", end_cyc, ack_cnt); end
  endtask

  task automatic test_reset_mid;
    start(0, 0, 0, 0, 10, 32'h50);
    for (int k = 0; k <= 7; k++) begin
      @(negedge clk);
      wr_en = 1'b0;
    end
    vectors++; if (ack_a !== 1'b1) begin miscompares++; $display("FAIL rstmid_beat4 got ack=%b want 1", ack_a); end
    rst = 1'b1;
    #1;
    vectors++; if ({cmd_a, ack_a, en_a, busy_a, end_a} !== {NOP, 4'b0}) begin miscompares++; $display("FAIL rstmid_ctrl got %b want %b", {cmd_a, ack_a, en_a, busy_a, end_a}, {NOP, 4'b0}); end
    vectors++; if ({bank_a, addr_a, dq_a} !== '0) begin miscompares++; $display("FAIL rstmid_bus got %h want 0", {bank_a, addr_a, dq_a}); end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      vectors++; if ({end_a, busy_a} !== 2'b00) begin miscompares++; $display("FAIL rstmid_hold c%0d got %b want 00", k, {end_a, busy_a}); end
    end
    rst = 1'b0;
    start(0, 2, 3, 4, 2, 32'h70);
    capture(0, 100, 32'h70);
    vectors++; if (end_cyc !== 11 || ack_cnt !== 2) begin miscompares++; $display("FAIL rstmid_after got end=%0d ack=%0d want 11,2", end_cyc, ack_cnt); end
    vectors++; if ({mem[key(2, 3, 4)], mem[key(2, 3, 5)]} !== {32'h70, 32'h71}) begin miscompares++; $display("FAIL rstmid_data got %h %h want 70 71", mem[key(2, 3, 4)], mem[key(2, 3, 5)]); end
  endtask

  task automatic test_wide_params;
    start(1, 0, 0, 0, 256, 32'hA000_0000);
    capture(1, 400, 32'hA000_0000);
    vectors++; if (first_ack !== 4) begin miscompares++; $display("FAIL wide_first_beat got %0d want 4", first_ack); end
    vectors++; if (ack_cnt !== 256) begin miscompares++; $display("FAIL wide_acks got %0d want 256", ack_cnt); end
    vectors++; if (end_cyc !== 266) begin miscompares++; $display("FAIL wide_end got %0d want 266", end_cyc); end
    vectors++; if (act_cnt !== 1) begin miscompares++; $display("FAIL wide_acts got %0d want 1", act_cnt); end
    vectors++; if ({mem[key(0, 0, 0)], mem[key(0, 0, 255)]} !== {32'hA000_0000, 32'hA000_00FF}) begin miscompares++; $display("FAIL wide_data got %h %h want a0000000 a00000ff", mem[key(0, 0, 0)], mem[key(0, 0, 255)]); end
    vectors++; if ({cmd_t[260], cmd_t[262]} !== {BST, PRE}) begin miscompares++; $display("FAIL wide_close got %b %b want BST PRE", cmd_t[260], cmd_t[262]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_page_cross();
    test_row_wrap();
    test_gating();
    test_reset_mid();
    test_wide_params();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
